dsp_issue_ctrl: RTL and testbench

Initiator-side controller that feeds the fracturable signed DSP multiplier and collects its products. It accepts tagged operand requests over a valid/ready handshake and drives the DSP's start/mode/operand inputs while honouring its initiation interval. It captures each product after the fixed DSP latency, sign-extends it according to the issuing mode, and returns results in issue order through a credit-protected response FIFO. It sits between the datapath scheduler and the DSP instance.

---
 rtl/dsp_pkg.sv | 37 +++
 rtl/dsp_rsp_fifo.sv | 60 ++++++
 rtl/dsp_issue_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dsp_issue_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared constants, issue FSM state type and product sign-extension helper
// for the fracturable DSP issue controller.
package dsp_pkg;

   localparam logic [1:0] MODE_5X5 = 2'b00;
   localparam logic [1:0] MODE_5X9 = 2'b01;
   localparam logic [1:0] MODE_NXM = 2'b10;

   localparam int PW_5X5 = 10;
   localparam int PW_5X9 = 15;

   // Working width of sext_product; callers keep the low bits they need.
   localparam int SEXT_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_HOLD   = 2'd2
   } issue_state_t;

   function automatic logic [SEXT_W-1:0] sext_product(
      input logic [1:0]        mode,
      input logic [SEXT_W-1:0] raw
   );
      logic [SEXT_W-1:0] res;
      res = raw;
      if ((mode & MODE_NXM) != 2'b00) begin
         res = raw;
      end else if (mode == MODE_5X9) begin
         res = {{(SEXT_W-PW_5X9){raw[PW_5X9-1]}}, raw[PW_5X9-1:0]};
      end else begin
         res = {{(SEXT_W-PW_5X5){raw[PW_5X5-1]}}, raw[PW_5X5-1:0]};
      end
      return res;
   endfunction

endpackage

// File: rtl/dsp_rsp_fifo.sv
// Response FIFO: DEPTH entries of W bits, wrap-around pointers, occupancy
// count. Head entry is presented directly on rd_data.
module dsp_rsp_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 20
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] rd_data,
   output logic         not_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [W-1:0]  mem_reg [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          pop_ok;

   assign pop_ok    = pop && (count_reg != '0);
   assign not_empty = (count_reg != '0);
   assign rd_data   = mem_reg[rd_ptr_reg];

   // Entries are cleared on reset so the head reads as zero while empty.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            mem_reg[gi] <= '0;
         end else if (push && (wr_ptr_reg == AW'(gi))) begin
            mem_reg[gi] <= push_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/dsp_issue_ctrl.sv
// Issue controller for the fracturable signed DSP multiplier: paces launches
// by II, tracks them through a LAT-deep pipeline and queues sign-extended results.
module dsp_issue_ctrl
   import dsp_pkg::*;
#(
   parameter int N     = 9,
   parameter int M     = 9,
   parameter int II    = 4,
   parameter int LAT   = 3,
   parameter int DEPTH = 4,
   parameter int TAGW  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_mode,
   input  logic [N-1:0]      req_a,
   input  logic [M-1:0]      req_b,
   input  logic [TAGW-1:0]   req_tag,
   output logic              dsp_start,
   output logic [1:0]        dsp_mode,
   output logic [N-1:0]      dsp_aa,
   output logic [M-1:0]      dsp_bb,
   input  logic [M+N-1:0]    dsp_out,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [M+N-1:0]    rsp_data,
   output logic [TAGW-1:0]   rsp_tag,
   output logic              busy
);

   localparam int P   = M + N;
   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int IIW = (II > 1) ? $clog2(II) : 1;

   issue_state_t    state_reg;
   issue_state_t    state_next;
   logic            ready_en_reg;
   logic [IIW-1:0]  ii_cnt_reg;
   logic [CW-1:0]   credits_reg;
   logic            accept;
   logic            pop;

   logic [LAT-1:0]  vld_pipe_reg;
   logic [1:0]      mode_pipe_reg [LAT];
   logic [TAGW-1:0] tag_pipe_reg  [LAT];

   logic              cap_valid;
   logic [SEXT_W-1:0] raw_ext;
   logic [SEXT_W-1:0] sext_ext;
   logic [P-1:0]      cap_data;

   // ready_en_reg holds req_ready low until the first edge after reset release.
   assign req_ready = ready_en_reg && (ii_cnt_reg == '0) && (credits_reg < CW'(DEPTH));
   assign accept    = req_valid && req_ready;
   assign pop       = rsp_valid && rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en_reg <= 1'b0;
         ii_cnt_reg   <= '0;
         credits_reg  <= '0;
         dsp_mode     <= '0;
         dsp_aa       <= '0;
         dsp_bb       <= '0;
      end else begin
         ready_en_reg <= 1'b1;
         if (accept) begin
            ii_cnt_reg <= IIW'(II - 1);
            dsp_mode   <= req_mode;
            dsp_aa     <= req_a;
            dsp_bb     <= req_b;
         end else if (ii_cnt_reg != '0) begin
            ii_cnt_reg <= ii_cnt_reg - 1'b1;
         end
         case ({accept, pop})
            2'b10:   credits_reg <= credits_reg + 1'b1;
            2'b01:   credits_reg <= credits_reg - 1'b1;
            default: credits_reg <= credits_reg;
         endcase
      end
   end

   // Issue FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Issue FSM: next state. HOLD can take a fresh accept once ii_cnt has drained.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept) state_next = ST_LAUNCH;
         end
         ST_LAUNCH: begin
            if (II > 1)      state_next = ST_HOLD;
            else if (accept) state_next = ST_LAUNCH;
            else             state_next = ST_IDLE;
         end
         ST_HOLD: begin
            if (accept)                  state_next = ST_LAUNCH;
            else if (ii_cnt_reg == '0)   state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Issue FSM: outputs
   always_comb begin
      dsp_start = (state_reg == ST_LAUNCH);
   end

   // Launch tracking; stage 0 is loaded on the accept edge so the tail
   // lines up with the edge where dsp_out holds the product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe_reg <= '0;
         for (int i = 0; i < LAT; i++) begin
            mode_pipe_reg[i] <= '0;
            tag_pipe_reg[i]  <= '0;
         end
      end else begin
         vld_pipe_reg[0]  <= accept;
         mode_pipe_reg[0] <= req_mode;
         tag_pipe_reg[0]  <= req_tag;
         for (int i = 1; i < LAT; i++) begin
            vld_pipe_reg[i]  <= vld_pipe_reg[i-1];
            mode_pipe_reg[i] <= mode_pipe_reg[i-1];
            tag_pipe_reg[i]  <= tag_pipe_reg[i-1];
         end
      end
   end

   assign cap_valid = vld_pipe_reg[LAT-1];
   assign raw_ext   = SEXT_W'(dsp_out);
   assign sext_ext  = sext_product(mode_pipe_reg[LAT-1], raw_ext);
   assign cap_data  = sext_ext[P-1:0];

   if (P < SEXT_W) begin : g_ext_hi
      logic unused_ext_hi;
      assign unused_ext_hi = ^sext_ext[SEXT_W-1:P];
   end

   dsp_rsp_fifo #(
      .DEPTH (DEPTH),
      .W     (P + TAGW)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (cap_valid),
      .push_data ({tag_pipe_reg[LAT-1], cap_data}),
      .pop       (pop),
      .rd_data   ({rsp_tag, rsp_data}),
      .not_empty (rsp_valid)
   );

   assign busy = (|vld_pipe_reg) || rsp_valid;

endmodule

// File: tb/tb_dsp_issue_ctrl.sv
// Directed bench for dsp_issue_ctrl with a small behavioural DSP that
// garbles unused product bits and drives junk when not started.
module tb_dsp_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_mode;
   logic [8:0]  req_a;
   logic [8:0]  req_b;
   logic [1:0]  req_tag;
   logic        dsp_start;
   logic [1:0]  dsp_mode;
   logic [8:0]  dsp_aa;
   logic [8:0]  dsp_bb;
   logic [17:0] dsp_out;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [17:0] rsp_data;
   logic [1:0]  rsp_tag;
   logic        busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dsp_issue_ctrl #(
      .N(9), .M(9), .II(4), .LAT(3), .DEPTH(4), .TAGW(2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_mode  (req_mode),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_tag   (req_tag),
      .dsp_start (dsp_start),
      .dsp_mode  (dsp_mode),
      .dsp_aa    (dsp_aa),
      .dsp_bb    (dsp_bb),
      .dsp_out   (dsp_out),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_tag   (rsp_tag),
      .busy      (busy)
   );

   // Fracturable multiplier: upper bits outside the mode's product are junk.
   function automatic logic [17:0] dsp_model(input logic [1:0] m, input logic [8:0] a, input logic [8:0] b);
      logic [9:0]  p10;
      logic [14:0] p15;
      logic [17:0] p18;
      p10 = {{5{a[4]}}, a[4:0]} * {{5{b[4]}}, b[4:0]};
      p15 = {{10{a[4]}}, a[4:0]} * {{6{b[8]}}, b};
      p18 = {{9{a[8]}}, a} * {{9{b[8]}}, b};
      if (m == 2'b00) return {8'hA5, p10};
      if (m == 2'b01) return {3'b101, p15};
      return p18;
   endfunction

   logic [17:0] dsp_p0;
   logic [17:0] dsp_p1;
   always @(posedge clk) begin
      dsp_p0 <= dsp_start ? dsp_model(dsp_mode, dsp_aa, dsp_bb) : 18'h2AAAA;
      dsp_p1 <= dsp_p0;
   end
   assign dsp_out = dsp_p1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge just after the accept edge.
   task automatic do_req(input logic [1:0] m, input logic [8:0] a, input logic [8:0] b, input logic [1:0] t);
      int n;
      n = 0;
      req_valid = 1'b1;
      req_mode  = m;
      req_a     = a;
      req_b     = b;
      req_tag   = t;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("req_wait", 32'(n < 50), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      check("start_pulse", 32'(dsp_start), 32'd1);
      $display("req  mode=%b a=%h b=%h tag=%0d", m, a, b, t);
   endtask

   task automatic run_one(input string name, input logic [1:0] m, input logic [8:0] a, input logic [8:0] b,
                          input logic [1:0] t, input logic [17:0] exp_data);
      do_req(m, a, b, t);
      check({name, "_aa"}, 32'(dsp_aa), 32'(a));
      @(negedge clk);
      @(negedge clk);
      check({name, "_early"}, 32'(rsp_valid), 32'd0);
      check({name, "_one_start"}, 32'(dsp_start), 32'd0);
      @(negedge clk);
      check({name, "_valid"}, 32'(rsp_valid), 32'd1);
      check({name, "_data"}, 32'(rsp_data), 32'(exp_data));
      check({name, "_tag"}, 32'(rsp_tag), 32'(t));
      $display("rsp  %s data=%h tag=%0d", name, rsp_data, rsp_tag);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({name, "_popped"}, 32'(rsp_valid), 32'd0);
      check({name, "_idle"}, 32'(busy), 32'd0);
   endtask

   logic [1:0] exp_tag [5];
   int         exp_dat [5];

   initial begin
      int  popped;
      int  tag_ctr;
      logic accepted;
      logic seen;

      exp_tag = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      exp_dat = '{22, 24, 26, 100, 120};

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_mode  = 2'b00;
      req_a     = '0;
      req_b     = '0;
      req_tag   = '0;
      rsp_ready = 1'b0;

      // Reset
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_dsp_start", 32'(dsp_start), 32'd0);
      check("rst_dsp_regs", 32'({dsp_mode, dsp_aa, dsp_bb}), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", 32'({rsp_tag, rsp_data}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      #1 check("rel_ready_low", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("rel_ready_high", 32'(req_ready), 32'd1);

      // Single transactions per mode
      run_one("m00", 2'b00, 9'h1FD, 9'h007, 2'd1, 18'h3FFEB);
      run_one("m10", 2'b10, 9'h100, 9'h100, 2'd2, 18'h10000);
      run_one("m01", 2'b01, 9'h1F0, 9'd255, 2'd3, 18'h3F010);
      run_one("m11", 2'b11, 9'h0FF, 9'h1FF, 2'd0, 18'h3FF01);

      // Initiation interval with req_valid held high
      rsp_ready = 1'b1;
      popped    = 0;
      tag_ctr   = 0;
      req_valid = 1'b1;
      req_mode  = 2'b10;
      req_a     = 9'd1;
      req_b     = 9'd3;
      req_tag   = 2'd0;
      for (int i = 0; i < 20; i++) begin
         check("ii_ready", 32'(req_ready), 32'(i % 4 == 0));
         if (i > 0) check("ii_start", 32'(dsp_start), 32'((i - 1) % 4 == 0));
         if (rsp_valid) begin
            check("ii_tag", 32'(rsp_tag), 32'(popped % 4));
            check("ii_data", 32'(rsp_data), 32'(3 * (popped + 1)));
            $display("rsp  ii data=%h tag=%0d", rsp_data, rsp_tag);
            popped++;
         end
         accepted = req_ready;
         @(negedge clk);
         if (accepted) begin
            tag_ctr++;
            req_tag = 2'(tag_ctr);
            req_a   = 9'(tag_ctr + 1);
         end
      end
      req_valid = 1'b0;
      for (int j = 0; j < 8; j++) begin
         if (rsp_valid) begin
            check("ii_tag", 32'(rsp_tag), 32'(popped % 4));
            check("ii_data", 32'(rsp_data), 32'(3 * (popped + 1)));
            $display("rsp  ii data=%h tag=%0d", rsp_data, rsp_tag);
            popped++;
         end
         @(negedge clk);
      end
      check("ii_count", 32'(popped), 32'd5);
      rsp_ready = 1'b0;

      // Backpressure and credits
      for (int t = 0; t < 4; t++) do_req(2'b10, 9'(10 + t), 9'd2, 2'(t));
      repeat (5) @(negedge clk);
      check("bp_full", 32'(req_ready), 32'd0);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_busy", 32'(busy), 32'd1);
      req_valid = 1'b1;
      req_mode  = 2'b10;
      req_a     = 9'd50;
      req_b     = 9'd2;
      req_tag   = 2'd0;
      repeat (3) begin
         @(negedge clk);
         check("bp_block", 32'(req_ready), 32'd0);
         check("bp_nostart", 32'(dsp_start), 32'd0);
      end
      check("bp_head_tag", 32'(rsp_tag), 32'd0);
      check("bp_head_data", 32'(rsp_data), 32'd20);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("bp_freed", 32'(req_ready), 32'd1);
      @(negedge clk);
      check("bp_5th_start", 32'(dsp_start), 32'd1);
      check("bp_full_again", 32'(req_ready), 32'd0);
      req_tag   = 2'd1;
      req_a     = 9'd60;
      rsp_ready = 1'b1;
      popped    = 0;
      for (int j = 0; j < 40 && popped < 5; j++) begin
         if (rsp_valid) begin
            check("bp_tag", 32'(rsp_tag), 32'(exp_tag[popped]));
            check("bp_data", 32'(rsp_data), 32'(exp_dat[popped]));
            $display("rsp  bp data=%h tag=%0d", rsp_data, rsp_tag);
            popped++;
         end
         accepted = req_valid && req_ready;
         @(negedge clk);
         if (accepted) req_valid = 1'b0;
      end
      req_valid = 1'b0;
      check("bp_count", 32'(popped), 32'd5);
      @(negedge clk);
      check("bp_drained", 32'(busy), 32'd0);
      check("bp_ready", 32'(req_ready), 32'd1);
      rsp_ready = 1'b0;

      // Reset with one result queued and one in flight
      do_req(2'b00, 9'd3, 9'd2, 2'd2);
      repeat (4) @(negedge clk);
      check("mr_queued", 32'(rsp_valid), 32'd1);
      do_req(2'b10, 9'd5, 9'd5, 2'd3);
      rst_n = 1'b0;
      #1;
      check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_start", 32'(dsp_start), 32'd0);
      check("mr_ready", 32'(req_ready), 32'd0);
      check("mr_dsp_regs", 32'({dsp_mode, dsp_aa, dsp_bb}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         seen = seen | rsp_valid;
      end
      check("mr_no_stale", 32'(seen), 32'd0);
      check("mr_ready_back", 32'(req_ready), 32'd1);
      // A leaked credit would stall one of these four.
      for (int t = 0; t < 4; t++) do_req(2'b10, 9'(t + 1), 9'd1, 2'(t));
      repeat (5) @(negedge clk);
      check("mr_credits_full", 32'(req_ready), 32'd0);
      check("mr_head_tag", 32'(rsp_tag), 32'd0);
      check("mr_head_data", 32'(rsp_data), 32'd1);
      rsp_ready = 1'b1;
      repeat (6) @(negedge clk);
      check("mr_final_idle", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
